// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I decode definitions: base opcodes, funct7 patterns, the ALU
// operation enum, the control bundle struct and the immediate-format selector,
// plus the funct3 -> ALU operation helpers used by the decoder.
//
// Configuration macro: DECODE_MEXT_EN
//   defined   -> the ALU enum widens to 5 bits and gains the eight M-extension
//                operations (MUL..REMU); funct7=0000001 on R-type is legal.
//   undefined -> 4-bit ALU enum, base RV32I operations only.
// -----------------------------------------------------------------------------
package riscv_pkg;

  // Base RV32I opcodes (instr[6:0])
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // R-type funct7 patterns
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef DECODE_MEXT_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  localparam int ALU_OP_W = 5;
`else
  localparam int ALU_OP_W = 4;
`endif

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 0,
    ALU_SUB    = 1,
    ALU_SLL    = 2,
    ALU_SLT    = 3,
    ALU_SLTU   = 4,
    ALU_XOR    = 5,
    ALU_SRL    = 6,
    ALU_SRA    = 7,
    ALU_OR     = 8,
    ALU_AND    = 9
`ifdef DECODE_MEXT_EN
    ,
    ALU_MUL    = 16,
    ALU_MULH   = 17,
    ALU_MULHSU = 18,
    ALU_MULHU  = 19,
    ALU_DIV    = 20,
    ALU_DIVU   = 21,
    ALU_REM    = 22,
    ALU_REMU   = 23
`endif
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_req;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
    alu_op_e alu_ctrl;
  } ctrl_t;

  // Base ALU selection shared by R-type and OP_IMM; 'alt' is funct7[5]
  // already qualified by the caller (OP_IMM only passes it for SRAI).
  function automatic alu_op_e alu_base(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

`ifdef DECODE_MEXT_EN
  function automatic alu_op_e alu_mext(input logic [2:0] funct3);
    alu_op_e op;
    op = ALU_MUL;
    case (funct3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction
`endif

endpackage

// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl
// Purely combinational RV32I instruction decoder.
//
// Ports:
//   i_instr     in  32    instruction word
//   o_ctrl      out       control bundle (flags + ALU operation)
//   o_imm       out XLEN  sign-extended immediate (0 for formats without one)
//   o_uses_rs1  out 1     instruction reads rs1
//   o_uses_rs2  out 1     instruction reads rs2
//
// Configuration macro: DECODE_MEXT_EN enables R-type funct7=0000001 (M ops);
// without it that encoding is flagged illegal.
// -----------------------------------------------------------------------------
module decode_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_r_legal_base;

  ctrl_t      w_ctrl;
  imm_sel_e   w_imm_sel;
  logic       w_uses_rs1;
  logic       w_uses_rs2;

  // Raw immediate fields, declared signed so a size cast sign-extends them.
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // funct7=0100000 is only defined for SUB (000) and SRA (101).
  assign w_r_legal_base = (w_funct7 == F7_BASE) ||
                          ((w_funct7 == F7_ALT) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

  always_comb begin
    w_ctrl          = '0;
    w_ctrl.alu_ctrl = ALU_ADD;
    w_imm_sel       = IMM_NONE;
    w_uses_rs1      = 1'b0;
    w_uses_rs2      = 1'b0;
    case (w_opcode)
      OP_R_TYPE: begin
        if (w_r_legal_base) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_ctrl  = alu_base(w_funct3, w_funct7[5]);
          w_uses_rs1       = 1'b1;
          w_uses_rs2       = 1'b1;
        end
`ifdef DECODE_MEXT_EN
        else if (w_funct7 == F7_MEXT) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_ctrl  = alu_mext(w_funct3);
          w_uses_rs1       = 1'b1;
          w_uses_rs2       = 1'b1;
        end
`endif
        else begin
          w_ctrl.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        // funct7[5] is part of the immediate except for the SRAI shift.
        w_ctrl.alu_ctrl  = alu_base(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        w_imm_sel        = IMM_I;
        w_uses_rs1       = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_req   = 1'b1;
        w_imm_sel        = IMM_I;
        w_uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_imm_sel        = IMM_S;
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.branch   = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
        w_imm_sel       = IMM_B;
        w_uses_rs1      = 1'b1;
        w_uses_rs2      = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_imm_sel        = IMM_U;
      end
      OP_JAL: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm_sel        = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm_sel        = IMM_I;
        w_uses_rs1       = 1'b1;
      end
      default: begin
        w_ctrl.illegal = 1'b1;
      end
    endcase
  end

  assign w_imm_i = i_instr[31:20];
  assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    o_imm = '0;
    case (w_imm_sel)
      IMM_I:   o_imm = XLEN'(w_imm_i);
      IMM_S:   o_imm = XLEN'(w_imm_s);
      IMM_B:   o_imm = XLEN'(w_imm_b);
      IMM_U:   o_imm = XLEN'(w_imm_u);
      IMM_J:   o_imm = XLEN'(w_imm_j);
      default: o_imm = '0;
    endcase
  end

  assign o_ctrl     = w_ctrl;
  assign o_uses_rs1 = w_uses_rs1;
  assign o_uses_rs2 = w_uses_rs2;

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered, handshaked RV32I decode stage between fetch and execute. Holds
// the output pipeline register, the valid/ready handshake and a scoreboard of
// registers with loads in flight; instructions that read such a register are
// stalled until the load writes back.
//
// Handshake: a transfer happens on a clk edge where valid && ready. The
// producer keeps valid and data stable until ready; ready never depends on
// valid. in_ready = (!out_valid | out_ready) & !hazard & !flush, and while
// out_valid && !out_ready every out_* field holds.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready        execute handshake
//   out_pc, out_rs1/rs2/rd     registered PC and register indices
//   out_imm, out_alu_ctrl      sign-extended immediate, ALU operation
//   out_reg_write .. illegal   control flags
//   wb_valid, wb_rd            load writeback clears scoreboard bit wb_rd
//   flush                      squash held bundle, block acceptance
//
// Configuration macro: DECODE_MEXT_EN (M-extension decode, needs ALU_W >= 5).
// -----------------------------------------------------------------------------
module decode_stage
  import riscv_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int ALU_W = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [RW-1:0]    out_rs1,
  output logic [RW-1:0]    out_rs2,
  output logic [RW-1:0]    out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [ALU_W-1:0] out_alu_ctrl,
  output logic             out_reg_write,
  output logic             out_mem_req,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_rd,
  input  logic             flush
);

  // The ALU enum is 5 bits wide when M ops are compiled in.
  if (ALU_W < ALU_OP_W) begin : g_alu_w_check
    $error("decode_stage: ALU_W is narrower than the ALU operation encoding");
  end

  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_is_load;
  logic [NREGS-1:0] w_sb_next;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [RW-1:0]    r_rs1;
  logic [RW-1:0]    r_rs2;
  logic [RW-1:0]    r_rd;
  logic [XLEN-1:0]  r_imm;
  ctrl_t            r_ctrl;
  logic [NREGS-1:0] r_sb;

  decode_ctrl #(
    .XLEN(XLEN)
  ) u_decode_ctrl (
    .i_instr    (in_instr),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  assign w_rs1 = RW'(in_instr[19:15]);
  assign w_rs2 = RW'(in_instr[24:20]);
  assign w_rd  = RW'(in_instr[11:7]);

  // Scoreboard is read with its registered value: a writeback in this cycle
  // only unblocks the dependent instruction on the next cycle.
  assign w_hazard = (w_uses_rs1 && (w_rs1 != '0) && r_sb[w_rs1]) ||
                    (w_uses_rs2 && (w_rs2 != '0) && r_sb[w_rs2]);

  assign w_in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept   = in_valid && w_in_ready;

  // Illegal instructions carry no flags, so they never look like a load.
  assign w_is_load = w_ctrl.mem_req && !w_ctrl.mem_write;

  always_comb begin
    w_sb_next = r_sb;
    if (wb_valid) begin
      w_sb_next[wb_rd] = 1'b0;
    end
    // Applied after the clear so a same-index set wins.
    if (w_accept && w_is_load && (w_rd != '0)) begin
      w_sb_next[w_rd] = 1'b1;
    end
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
      r_sb    <= '0;
    end else begin
      r_sb <= w_sb_next;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pc    <= in_pc;
        r_rs1   <= w_rs1;
        r_rs2   <= w_rs2;
        r_rd    <= w_rd;
        r_imm   <= w_imm;
        r_ctrl  <= w_ctrl;
      end else if (flush || out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_rd        = r_rd;
  assign out_imm       = r_imm;
  assign out_alu_ctrl  = ALU_W'(r_ctrl.alu_ctrl);
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_req   = r_ctrl.mem_req;
  assign out_mem_write = r_ctrl.mem_write;
  assign out_branch    = r_ctrl.branch;
  assign out_jump      = r_ctrl.jump;
  assign out_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage: reset values, decode of each format,
// load-use stall and writeback release, backpressure hold, flush, illegal
// encodings, scoreboard set/clear collision and reset of a held bundle.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RW    = 5;
`ifdef DECODE_MEXT_EN
  localparam int ALU_W = 5;
`else
  localparam int ALU_W = 4;
`endif

  // ALU codes written out by hand
  localparam logic [31:0] A_ADD = 32'd0;
  localparam logic [31:0] A_SUB = 32'd1;
  localparam logic [31:0] A_SRA = 32'd7;
  localparam logic [31:0] A_MUL = 32'd16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [RW-1:0]    out_rs1;
  logic [RW-1:0]    out_rs2;
  logic [RW-1:0]    out_rd;
  logic [XLEN-1:0]  out_imm;
  logic [ALU_W-1:0] out_alu_ctrl;
  logic             out_reg_write;
  logic             out_mem_req;
  logic             out_mem_write;
  logic             out_branch;
  logic             out_jump;
  logic             out_illegal;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             flush;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decode_stage #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .ALU_W(ALU_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_alu_ctrl (out_alu_ctrl),
    .out_reg_write(out_reg_write),
    .out_mem_req  (out_mem_req),
    .out_mem_write(out_mem_write),
    .out_branch   (out_branch),
    .out_jump     (out_jump),
    .out_illegal  (out_illegal),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush)
  );

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    flush     = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_alu", 32'(out_alu_ctrl), 32'd0);
    chk("rst_regw", 32'(out_reg_write), 32'd0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    #1;
    chk("add_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    issue(32'h002081B3, 32'h100);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_rs1", 32'(out_rs1), 32'd1);
    chk("add_rs2", 32'(out_rs2), 32'd2);
    chk("add_regw", 32'(out_reg_write), 32'd1);
    chk("add_alu", 32'(out_alu_ctrl), A_ADD);
    chk("add_illegal", 32'(out_illegal), 32'd0);
    chk("add_pc", out_pc, 32'h100);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // lw x5,8(x1) followed by dependent add x6,x5,x0
    issue(32'h0080A283, 32'h200);
    chk("lw_imm", out_imm, 32'd8);
    chk("lw_memreq", 32'(out_mem_req), 32'd1);
    chk("lw_memwr", 32'(out_mem_write), 32'd0);
    chk("lw_regw", 32'(out_reg_write), 32'd1);
    chk("lw_rd", 32'(out_rd), 32'd5);
    in_valid = 1'b1;
    in_instr = 32'h00028333;
    in_pc    = 32'h204;
    #1;
    chk("lu_stall0", 32'(in_ready), 32'd0);
    tick();
    chk("lu_drained", 32'(out_valid), 32'd0);
    chk("lu_stall1", 32'(in_ready), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    chk("lu_no_bypass", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("lu_released", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lu_add_valid", 32'(out_valid), 32'd1);
    chk("lu_add_rd", 32'(out_rd), 32'd6);
    chk("lu_add_rs1", 32'(out_rs1), 32'd5);
    tick();

    // sw x2,-4(x1) under backpressure
    out_ready = 1'b0;
    issue(32'hFE20AE23, 32'h300);
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc    = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_in_ready", 32'(in_ready), 32'd0);
      chk("sw_valid", 32'(out_valid), 32'd1);
      chk("sw_imm", out_imm, 32'hFFFFFFFC);
      chk("sw_memwr", 32'(out_mem_write), 32'd1);
      chk("sw_regw", 32'(out_reg_write), 32'd0);
      chk("sw_rs2", 32'(out_rs2), 32'd2);
      chk("sw_pc", out_pc, 32'h300);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("sw_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("after_sw_rd", 32'(out_rd), 32'd3);
    chk("after_sw_memwr", 32'(out_mem_write), 32'd0);
    chk("after_sw_imm", out_imm, 32'd0);
    tick();

    // Flush with a held bundle and a simultaneous valid instruction
    out_ready = 1'b0;
    issue(32'h00002483, 32'h400);  // lw x9,0(x0)
    chk("fl_held", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    flush    = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00048533;      // add x10,x9,x0
    #1;
    chk("fl_sb_kept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("fl_sb_cleared", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();

    // Further formats
    issue(32'h402081B3, 32'h500);  // sub x3,x1,x2
    chk("sub_alu", 32'(out_alu_ctrl), A_SUB);
    issue(32'h4030D213, 32'h504);  // srai x4,x1,3
    chk("srai_alu", 32'(out_alu_ctrl), A_SRA);
    chk("srai_imm", out_imm, 32'h403);
    issue(32'hFE208CE3, 32'h508);  // beq x1,x2,-8
    chk("beq_imm", out_imm, 32'hFFFFFFF8);
    chk("beq_branch", 32'(out_branch), 32'd1);
    chk("beq_alu", 32'(out_alu_ctrl), A_SUB);
    chk("beq_regw", 32'(out_reg_write), 32'd0);
    issue(32'h123452B7, 32'h50C);  // lui x5,0x12345
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_regw", 32'(out_reg_write), 32'd1);
    issue(32'h010000EF, 32'h510);  // jal x1,+16
    chk("jal_imm", out_imm, 32'd16);
    chk("jal_jump", 32'(out_jump), 32'd1);
    chk("jal_rd", 32'(out_rd), 32'd1);

    // Illegal encodings
    issue(32'h00000000, 32'h600);
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_illegal", 32'(out_illegal), 32'd1);
    chk("zero_regw", 32'(out_reg_write), 32'd0);
    chk("zero_memreq", 32'(out_mem_req), 32'd0);
    issue(32'h022081B3, 32'h604);  // mul x3,x1,x2
`ifdef DECODE_MEXT_EN
    chk("mul_illegal", 32'(out_illegal), 32'd0);
    chk("mul_alu", 32'(out_alu_ctrl), A_MUL);
    chk("mul_regw", 32'(out_reg_write), 32'd1);
`else
    chk("mul_illegal", 32'(out_illegal), 32'd1);
    chk("mul_regw", 32'(out_reg_write), 32'd0);
`endif
    issue(32'h402091B3, 32'h608);  // funct7=0100000 with SLL: reserved
    chk("rsv_illegal", 32'(out_illegal), 32'd1);
    chk("rsv_regw", 32'(out_reg_write), 32'd0);

    // Writeback on x7 in the same cycle lw x7 is accepted: set wins
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    issue(32'h00002383, 32'h700);  // lw x7,0(x0)
    wb_valid = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00038433;       // add x8,x7,x0
    #1;
    chk("sb_set_wins", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Reset while a bundle is held; scoreboard also clears
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rd", 32'(out_rd), 32'd0);
    chk("mid_rst_memreq", 32'(out_mem_req), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00038433;
    #1;
    chk("mid_rst_sb", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
